// File: rtl/umai_pkg.sv
// Shared widths, FSM state type and burst helper for the UMAI memory slave.
package umai_pkg;

    localparam int UMAI_DATA_W = 512;
    localparam int UMAI_ADDR_W = 32;
    localparam int UMAI_LEN_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } umai_mem_state_e;

    // Number of beats carried by a command whose length field is len.
    function automatic logic [UMAI_LEN_W:0] beats(input logic [UMAI_LEN_W-1:0] len);
        return {1'b0, len} + {{UMAI_LEN_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/umai_mem_array.sv
// Depth x DataWidth flop storage: one synchronous write port, one
// combinational read port. Contents are never reset.
module umai_mem_array #(
    parameter int DataWidth = 512,
    parameter int Depth     = 64,
    parameter int IdxW      = $clog2(Depth)
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [IdxW-1:0]      i_waddr,
    input  logic [DataWidth-1:0] i_wdata,
    input  logic [IdxW-1:0]      i_raddr,
    output logic [DataWidth-1:0] o_rdata
);

    logic [DataWidth-1:0] mem_q [Depth];

    // Write one word per enabled cycle.
    // NOTE: no reset on storage; a reset would add a clear path to every bit
    // and buys nothing since reads are only meaningful after a write.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/umai_mem_slv.sv
// UMAI slave memory model / scratch target. Accepts write and read commands,
// alternating between them when both are pending, and serves bursts from a
// flop array with word index = addr[log2(Depth)+5:6] (modulo Depth).
// Optional macro UMAI_MEM_STATS_EN adds saturating write/read beat counters
// on ports o_wr_beats / o_rd_beats.
module umai_mem_slv
    import umai_pkg::*;
#(
    parameter int DataWidth = UMAI_DATA_W,
    parameter int AddrWidth = UMAI_ADDR_W,
    parameter int LenWidth  = UMAI_LEN_W,
    parameter int Depth     = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_umai_wcmd_valid,
    output logic                 o_umai_wcmd_ready,
    input  logic [AddrWidth-1:0] i_umai_wcmd_addr,
    input  logic [LenWidth-1:0]  i_umai_wcmd_len,
    input  logic                 i_umai_rcmd_valid,
    output logic                 o_umai_rcmd_ready,
    input  logic [AddrWidth-1:0] i_umai_rcmd_addr,
    input  logic [LenWidth-1:0]  i_umai_rcmd_len,
    input  logic                 i_umai_wvalid,
    output logic                 o_umai_wready,
    input  logic [DataWidth-1:0] i_umai_wdata,
    output logic                 o_umai_rvalid,
    input  logic                 i_umai_rready,
    output logic [DataWidth-1:0] o_umai_rdata
`ifdef UMAI_MEM_STATS_EN
    ,
    output logic [31:0]          o_wr_beats,
    output logic [31:0]          o_rd_beats
`endif
);

    localparam int IdxW = $clog2(Depth);
    localparam logic [IdxW-1:0]     IdxOne = IdxW'(1);
    localparam logic [LenWidth-1:0] LenOne = LenWidth'(1);

    umai_mem_state_e      state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [LenWidth-1:0]  cnt_q, cnt_d;
    logic                 last_rd_q, last_rd_d;   // last grant went to the read side
    logic                 rd_done_q, rd_done_d;   // every beat of the read has been issued
    logic                 rvalid_q, rvalid_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    logic [IdxW-1:0]      widx, ridx, mem_raddr;
    logic [DataWidth-1:0] mem_rdata;
    logic                 wcmd_fire, rcmd_fire, wr_fire, rd_issue, rd_accept;
    logic                 unused_addr_bits;

    assign widx = i_umai_wcmd_addr[IdxW+5:6];
    assign ridx = i_umai_rcmd_addr[IdxW+5:6];
    assign unused_addr_bits = ^{i_umai_wcmd_addr[AddrWidth-1:IdxW+6], i_umai_wcmd_addr[5:0],
                                i_umai_rcmd_addr[AddrWidth-1:IdxW+6], i_umai_rcmd_addr[5:0]};

    // Command readies: only in IDLE; on a tie the side not granted last time wins.
    assign o_umai_wcmd_ready = !i_rst && (state_q == IDLE) && i_umai_wcmd_valid &&
                               (!i_umai_rcmd_valid || last_rd_q);
    assign o_umai_rcmd_ready = !i_rst && (state_q == IDLE) && i_umai_rcmd_valid &&
                               (!i_umai_wcmd_valid || !last_rd_q);
    assign o_umai_wready     = !i_rst && (state_q == WR);
    assign o_umai_rvalid     = rvalid_q;
    assign o_umai_rdata      = rdata_q;

    assign wcmd_fire = i_umai_wcmd_valid && o_umai_wcmd_ready;
    assign rcmd_fire = i_umai_rcmd_valid && o_umai_rcmd_ready;
    assign wr_fire   = i_umai_wvalid && o_umai_wready;
    assign rd_accept = rvalid_q && i_umai_rready;
    assign rd_issue  = (state_q == RD) && !rd_done_q && (!rvalid_q || i_umai_rready);

    // The first read beat is fetched straight from the command address so that
    // rvalid rises the cycle after acceptance; later beats walk ptr.
    assign mem_raddr = (state_q == RD) ? ptr_q : ridx;

    umai_mem_array #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (wr_fire),
        .i_waddr (ptr_q),
        .i_wdata (i_umai_wdata),
        .i_raddr (mem_raddr),
        .o_rdata (mem_rdata)
    );

    // Next-state logic for the command / burst FSM and the read output register.
    // NOTE: every _d takes its _q value first so no path leaves it unassigned,
    // which keeps this block free of inferred latches.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        rd_done_d = rd_done_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (wcmd_fire) begin
                    ptr_d     = widx;
                    cnt_d     = i_umai_wcmd_len;
                    last_rd_d = 1'b0;
                    state_d   = WR;
                end else if (rcmd_fire) begin
                    rdata_d   = mem_rdata;
                    rvalid_d  = 1'b1;
                    ptr_d     = ridx + IdxOne;
                    cnt_d     = i_umai_rcmd_len - LenOne;
                    rd_done_d = (i_umai_rcmd_len == '0);
                    last_rd_d = 1'b1;
                    state_d   = RD;
                end
            end
            WR: begin
                if (wr_fire) begin
                    ptr_d = ptr_q + IdxOne;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - LenOne;
                    end
                end
            end
            RD: begin
                if (rd_issue) begin
                    rdata_d  = mem_rdata;
                    rvalid_d = 1'b1;
                    ptr_d    = ptr_q + IdxOne;
                    if (cnt_q == '0) begin
                        rd_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - LenOne;
                    end
                end else if (rd_accept) begin
                    rvalid_d = 1'b0;
                    if (rd_done_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; a reset drops any burst in flight.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            last_rd_q <= 1'b1;
            rd_done_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            last_rd_q <= last_rd_d;
            rd_done_q <= rd_done_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef UMAI_MEM_STATS_EN
    logic [31:0] wr_beats_q, rd_beats_q;

    // Saturating counters of accepted write and read beats.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_beats_q <= '0;
            rd_beats_q <= '0;
        end else begin
            if (wr_fire && (wr_beats_q != '1)) wr_beats_q <= wr_beats_q + 32'd1;
            if (rd_accept && (rd_beats_q != '1)) rd_beats_q <= rd_beats_q + 32'd1;
        end
    end

    assign o_wr_beats = wr_beats_q;
    assign o_rd_beats = rd_beats_q;
`endif

endmodule

// File: tb/tb_umai_mem_slv.sv
// Self-checking bench for umai_mem_slv: directed scenarios plus random
// bursts compared against a word-array reference of the memory.
module tb_umai_mem_slv;
    import umai_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst = 1'b1;
    logic                   wcmd_valid = 1'b0, wcmd_ready;
    logic [UMAI_ADDR_W-1:0] wcmd_addr = '0;
    logic [UMAI_LEN_W-1:0]  wcmd_len = '0;
    logic                   rcmd_valid = 1'b0, rcmd_ready;
    logic [UMAI_ADDR_W-1:0] rcmd_addr = '0;
    logic [UMAI_LEN_W-1:0]  rcmd_len = '0;
    logic                   wvalid = 1'b0, wready;
    logic [UMAI_DATA_W-1:0] wdata = '0;
    logic                   rvalid, rready = 1'b0;
    logic [UMAI_DATA_W-1:0] rdata;
`ifdef UMAI_MEM_STATS_EN
    logic [31:0]            wr_beats, rd_beats;
`endif

    int errors = 0;
    int checks = 0;
    logic [UMAI_DATA_W-1:0] model_mem [DEPTH];
    int unsigned wr_model = 0;
    int unsigned rd_model = 0;

    umai_mem_slv dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_umai_wcmd_valid (wcmd_valid),
        .o_umai_wcmd_ready (wcmd_ready),
        .i_umai_wcmd_addr  (wcmd_addr),
        .i_umai_wcmd_len   (wcmd_len),
        .i_umai_rcmd_valid (rcmd_valid),
        .o_umai_rcmd_ready (rcmd_ready),
        .i_umai_rcmd_addr  (rcmd_addr),
        .i_umai_rcmd_len   (rcmd_len),
        .i_umai_wvalid     (wvalid),
        .o_umai_wready     (wready),
        .i_umai_wdata      (wdata),
        .o_umai_rvalid     (rvalid),
        .i_umai_rready     (rready),
        .o_umai_rdata      (rdata)
`ifdef UMAI_MEM_STATS_EN
        ,
        .o_wr_beats        (wr_beats),
        .o_rd_beats        (rd_beats)
`endif
    );

    task automatic check(input string tag, input logic [UMAI_DATA_W-1:0] obs,
                         input logic [UMAI_DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [UMAI_DATA_W-1:0] rand512();
        logic [UMAI_DATA_W-1:0] r;
        for (int i = 0; i < UMAI_DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic int word_of(input logic [UMAI_ADDR_W-1:0] addr);
        return int'((addr >> 6) % DEPTH);
    endfunction

    task automatic check_stats();
`ifdef UMAI_MEM_STATS_EN
        check("wr_beats", 512'(wr_beats), 512'(wr_model));
        check("rd_beats", 512'(rd_beats), 512'(rd_model));
`endif
    endtask

    // Reset with every valid raised: readies must stay low throughout.
    task automatic do_reset();
        rst = 1'b1; wcmd_valid = 1'b1; rcmd_valid = 1'b1; wvalid = 1'b1; rready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wcmd_ready", 512'(wcmd_ready), 512'(0));
        check("rst_rcmd_ready", 512'(rcmd_ready), 512'(0));
        check("rst_wready", 512'(wready), 512'(0));
        wcmd_valid = 1'b0; rcmd_valid = 1'b0; wvalid = 1'b0; rready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; wr_model = 0; rd_model = 0;
        @(negedge clk);
        check("rst_rvalid", 512'(rvalid), 512'(0));
        check("rst_rdata", rdata, '0);
        check_stats();
        @(posedge clk); #1;
    endtask

    // Present a command; the slave is always idle here so it must be taken at once.
    task automatic issue_cmd(input bit is_rd, input logic [UMAI_ADDR_W-1:0] addr,
                             input logic [UMAI_LEN_W-1:0] len);
        int cyc = 0;
        string tag;
        tag = is_rd ? "rcmd_wait" : "wcmd_wait";
        if (is_rd) begin rcmd_valid = 1'b1; rcmd_addr = addr; rcmd_len = len; end
        else       begin wcmd_valid = 1'b1; wcmd_addr = addr; wcmd_len = len; end
        @(negedge clk);
        while (!(is_rd ? rcmd_ready : wcmd_ready) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 512'(cyc), 512'(0));
        @(posedge clk); #1;
        rcmd_valid = 1'b0; wcmd_valid = 1'b0;
    endtask

    // Write burst; abort_at >= 0 pulses reset before that beat.
    task automatic write_burst(input logic [UMAI_ADDR_W-1:0] addr, input logic [UMAI_LEN_W-1:0] len,
                               input bit fixed, input logic [UMAI_DATA_W-1:0] fixed_d,
                               input bit gaps, input int abort_at);
        int idx = word_of(addr);
        int n = int'(beats(len));
        issue_cmd(1'b0, addr, len);
        for (int b = 0; b < n; b++) begin
            if (b == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; wr_model = 0; rd_model = 0;
                return;
            end
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            wdata  = fixed ? (fixed_d ^ UMAI_DATA_W'(b)) : rand512();
            wvalid = 1'b1;
            @(negedge clk);
            check("wready", 512'(wready), 512'(1));
            @(posedge clk); #1;
            wvalid = 1'b0;
            model_mem[idx] = wdata;
            idx = (idx + 1) % DEPTH;
            wr_model++;
        end
    endtask

    // Read burst; mode 0 rready high, 1 pattern 1,0,0, 2 random. abort_at >= 0
    // pulses reset while that beat is on the bus.
    task automatic read_burst(input logic [UMAI_ADDR_W-1:0] addr, input logic [UMAI_LEN_W-1:0] len,
                              input int mode, input int abort_at);
        logic [UMAI_DATA_W-1:0] exp_q[$];
        logic [UMAI_DATA_W-1:0] held = '0;
        bit stalled = 1'b0;
        int got = 0;
        int k = 0;
        int n = int'(beats(len));
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(word_of(addr) + i) % DEPTH]);
        issue_cmd(1'b1, addr, len);
        while (got < n && k < 400) begin
            if (got == abort_at) begin
                rready = 1'b0; rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; wr_model = 0; rd_model = 0;
                @(negedge clk);
                check("abort_rvalid", 512'(rvalid), 512'(0));
                check("abort_rdata", rdata, '0);
                @(posedge clk); #1;
                return;
            end
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (k == 0) check("rd_first_valid", 512'(rvalid), 512'(1));
            if (stalled) begin
                check("stall_rvalid", 512'(rvalid), 512'(1));
                check("stall_rdata", rdata, held);
            end
            if (rvalid && rready) begin
                check("rdata", rdata, exp_q[got]);
                got++;
                rd_model++;
                stalled = 1'b0;
            end else begin
                stalled = rvalid;
                held    = rdata;
            end
            @(posedge clk); #1;
            k++;
        end
        rready = 1'b0;
        check("rd_beats_delivered", 512'(got), 512'(n));
        @(negedge clk);
        check("rd_idle_rvalid", 512'(rvalid), 512'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [UMAI_DATA_W-1:0] d;
        do_reset();

        // Arbitration from reset: both sides pending, grants alternate W,R,W,R.
        wcmd_valid = 1'b1; wcmd_addr = 32'h140; wcmd_len = '0;
        rcmd_valid = 1'b1; rcmd_addr = 32'h140; rcmd_len = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arb_wcmd_ready", 512'(wcmd_ready), 512'(i % 2 == 0));
            check("arb_rcmd_ready", 512'(rcmd_ready), 512'(i % 2 == 1));
            @(posedge clk); #1;
            if (i % 2 == 0) begin
                d = rand512(); wdata = d; wvalid = 1'b1;
                @(negedge clk);
                check("arb_w_hold_w", 512'(wcmd_ready), 512'(0));
                check("arb_w_hold_r", 512'(rcmd_ready), 512'(0));
                check("arb_wready", 512'(wready), 512'(1));
                @(posedge clk); #1;
                wvalid = 1'b0;
                model_mem[word_of(wcmd_addr)] = d;
                wr_model++;
                wcmd_addr = 32'h180;
            end else begin
                rready = 1'b1;
                @(negedge clk);
                check("arb_r_hold_w", 512'(wcmd_ready), 512'(0));
                check("arb_r_hold_r", 512'(rcmd_ready), 512'(0));
                check("arb_rvalid", 512'(rvalid), 512'(1));
                check("arb_rdata", rdata, model_mem[word_of(rcmd_addr)]);
                @(posedge clk); #1;
                rready = 1'b0;
                rd_model++;
                rcmd_addr = 32'h180;
            end
        end
        wcmd_valid = 1'b0; rcmd_valid = 1'b0;
        check_stats();

        // Fill all words with a maximum-length burst.
        write_burst(32'h0, 6'd63, 1'b0, '0, 1'b0, -1);

        // Single write then read; stray wvalid in IDLE must not write.
        write_burst(32'h40, 6'd0, 1'b1, {16{32'hA5A5_0001}}, 1'b0, -1);
        wvalid = 1'b1; wdata = ~{16{32'hA5A5_0001}};
        repeat (2) begin
            @(negedge clk);
            check("idle_wready", 512'(wready), 512'(0));
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        read_burst(32'h40, 6'd0, 0, -1);
        check("single_rw_word", model_mem[1], {16{32'hA5A5_0001}});

        // Wrap-around burst at the last word, then index 0 holds D1.
        write_burst(32'h0FC0, 6'd3, 1'b0, '0, 1'b0, -1);
        read_burst(32'h0FC0, 6'd3, 0, -1);
        read_burst(32'h0, 6'd0, 0, -1);

        // Backpressure on an 8-beat read; aliasing of high and low address bits.
        read_burst(32'h200, 6'd7, 1, -1);
        read_burst(32'h0000_1047, 6'd0, 0, -1);

        // Reset mid-read and mid-write; partial writes survive.
        read_burst(32'h0, 6'd7, 0, 2);
        read_burst(32'h40, 6'd0, 0, -1);
        write_burst(32'h400, 6'd7, 1'b0, '0, 1'b0, 3);
        read_burst(32'h400, 6'd7, 2, -1);

        // Random traffic.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1)
                read_burst($urandom(), 6'($urandom_range(0, 15)), int'($urandom_range(0, 2)), -1);
            else
                write_burst($urandom(), 6'($urandom_range(0, 15)), 1'b0, '0, 1'($urandom_range(0, 1)), -1);
        end
        check_stats();

        // Stats: 5 write beats and 7 read beats after a clean reset.
        do_reset();
        write_burst(32'h800, 6'd4, 1'b0, '0, 1'b0, -1);
        read_burst(32'h800, 6'd6, 1, -1);
        check_stats();
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/umai_mem_slv.md
Name: umai_mem_slv

Overview:
- UMAI slave memory model and on-chip scratch target.
- Sits directly downstream of the AIB top's UMAI master port.
- Consumes write commands, write data and read commands, and returns read data from a flop-based buffer of Depth 512-bit words.
- Used as the loopback/scratch endpoint for bring-up and as the standard sim target in place of tied-off ready/valid signals.

Parameters:
- DataWidth, 512, beat width in bits.
- AddrWidth, 32, command address width; byte address.
- LenWidth, 6, command length field; beats = len + 1 (1..64).
- Depth, 64, number of storage words; power of two.

Ports:
- i_clk  input  1  single clock (driven from the IP bus clock).
- i_rst  input  1  synchronous, active-high reset.
- i_umai_wcmd_valid  input  1  write command valid.
- o_umai_wcmd_ready  output  1  write command accepted.
- i_umai_wcmd_addr  input  AddrWidth  write byte address.
- i_umai_wcmd_len  input  LenWidth  write beats minus 1.
- i_umai_rcmd_valid  input  1  read command valid.
- o_umai_rcmd_ready  output  1  read command accepted.
- i_umai_rcmd_addr  input  AddrWidth  read byte address.
- i_umai_rcmd_len  input  LenWidth  read beats minus 1.
- i_umai_wvalid  input  1  write data valid.
- o_umai_wready  output  1  write data ready.
- i_umai_wdata  input  DataWidth  write beat.
- o_umai_rvalid  output  1  read data valid.
- i_umai_rready  input  1  read data ready.
- o_umai_rdata  output  DataWidth  read beat.

Behaviour:
- Reset:
  - Outputs: all readies = 0, o_umai_rvalid = 0, o_umai_rdata = 0.
  - Internal: FSM = IDLE, last_grant = READ.
  - Storage contents are not reset.
- Handshake: a transfer occurs on valid & ready in the same cycle. Valid must not depend on ready.
- Word index: addr[log2(Depth)+5 : 6]. Addr bits [5:0] are ignored. Addresses beyond Depth alias, i.e. index modulo Depth.
- FSM states: IDLE, WR, RD.
- IDLE:
  - o_umai_wcmd_ready / o_umai_rcmd_ready are driven combinationally, at most one high.
  - Only one valid: grant it.
  - Both valid: grant the opposite of last_grant (alternating; no starvation).
  - On an accepted command, latch ptr = word index and cnt = len, update last_grant, then go to WR or RD.
- WR:
  - o_umai_wready = 1.
  - Each beat writes mem[ptr]; ptr increments and wraps at Depth-1 -> 0; cnt decrements.
  - The beat taken with cnt == 0 is the last; next state is IDLE.
  - Command readies are 0 while in WR.
- RD:
  - Output register loads mem[ptr] whenever !o_umai_rvalid || i_umai_rready, while beats remain to issue.
  - First beat: rvalid asserts the cycle after rcmd acceptance.
  - Throughput: 1 beat/cycle with rready held high.
  - Backpressure: rdata and rvalid hold stable while rvalid & !rready.
  - ptr wraps as in WR.
  - After the last beat issues, return to IDLE once that beat is accepted (rvalid & rready). Next command acceptance is no earlier than that cycle.
- wvalid asserted outside WR is ignored: wready stays 0 and no write occurs.
- Ordering: commands are serviced strictly in acceptance order. A read following a write to the same index returns the new data.
- Reset mid-burst: in the next cycle FSM = IDLE, rvalid = 0, the remaining burst is dropped, and partial writes already made remain in storage.

Optional Feature:
- Macro: UMAI_MEM_STATS_EN.
- Defined:
  - Adds outputs o_wr_beats (32-bit) and o_rd_beats (32-bit).
  - o_wr_beats counts accepted write beats; o_rd_beats counts accepted read beats (rvalid & rready).
  - Both saturate at 0xFFFF_FFFF and are cleared by i_rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- umai_pkg:
  - Width constants UMAI_DATA_W = 512, UMAI_ADDR_W = 32, UMAI_LEN_W = 6.
  - umai_mem_state_e enum {IDLE, WR, RD}.
  - Function beats(len) = len + 1.
- Sub-module umai_mem_array: Depth x DataWidth flop storage, one synchronous write port, one combinational read port. No reset on contents.

Test Plan:
- Single write, then read: wcmd addr 0x0000_0040 len 0, wdata = {16{32'hA5A5_0001}}; then rcmd addr 0x40 len 0 -> rvalid 1 cycle after rcmd accept, rdata matches, FSM returns to IDLE.
- Burst wrap-around: wcmd addr 0x0FC0 (index 63) len 3, data D0..D3; read addr 0x0FC0 len 3 -> returns D0..D3 in order (indices 63, 0, 1, 2). Read addr 0x0 len 0 -> D1.
- Backpressure: 8-beat read with rready toggled 1,0,0,1,... -> rdata/rvalid stable while stalled; exactly 8 beats delivered, no duplicates; IDLE after the 8th accept.
- Arbitration: wcmd and rcmd valid simultaneously for 4 consecutive commands from reset -> grants W, R, W, R; each command's ready is high for exactly 1 cycle.
- Reset mid-burst: i_rst pulsed during beat 3 of an 8-beat read -> next cycle rvalid = 0, both command readies reflect IDLE. A new 1-beat read completes correctly.
- UMAI_MEM_STATS_EN: 5 write beats + 7 read beats -> o_wr_beats = 5, o_rd_beats = 7. After i_rst both are 0. Compile without the macro -> elaborates with no stats ports.
